// File: rtl/inv_seq_ctrl.sv
// Sequential front-end for the combinational prime-field inversion IP: buffers a prime + operand packet,
// issues one operand per cycle and streams inverses back in order. Define INV_CHECK_EN to add a result checker stage.
module inv_seq_ctrl #(
    parameter int IP_WIDTH = 5,
    parameter int MAX_LEN  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IP_WIDTH-1:0] in_data,
    output logic [IP_WIDTH-1:0] ip_in_1,
    output logic [IP_WIDTH-1:0] ip_in_2,
    input  logic [IP_WIDTH-1:0] ip_out_inv,
    output logic                out_valid,
    output logic [IP_WIDTH-1:0] out_data,
    output logic                out_err,
    output logic                busy
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IP_WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [IP_WIDTH-1:0] ip_in_1_q, ip_in_1_d;
    logic [IP_WIDTH-1:0] ip_in_2_q, ip_in_2_d;
    logic                iss_v_q, iss_v_d;
    logic                iss_err_q, iss_err_d;
    logic                out_valid_q, out_valid_d;
    logic [IP_WIDTH-1:0] out_data_q, out_data_d;
    logic                out_err_q, out_err_d;

    logic [IP_WIDTH-1:0] buf_q [MAX_LEN];
    logic                buf_we;
    logic                do_issue;
    logic [CW-1:0]       issue_idx;
    logic [IP_WIDTH-1:0] issue_a;
    logic                pipe_empty;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        buf_we    = 1'b0;
        do_issue  = 1'b0;
        issue_idx = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    p_d      = in_data;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (count_q != MAX_CNT) begin
                        buf_we  = 1'b1;
                        count_d = count_q + ONE;
                    end
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    // First operand goes out on the same edge that closes the packet.
                    do_issue = 1'b1;
                    rd_ptr_d = ONE;
                    state_d  = (count_q == ONE) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                do_issue  = 1'b1;
                issue_idx = rd_ptr_q;
                rd_ptr_d  = rd_ptr_q + ONE;
                if (rd_ptr_q == count_q - ONE) state_d = S_DONE;
            end
            S_DONE: begin
                if (pipe_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign issue_a   = buf_q[issue_idx[AW-1:0]];
    assign ip_in_1_d = do_issue ? issue_a : ip_in_1_q;
    assign ip_in_2_d = do_issue ? p_q : ip_in_2_q;
    assign iss_v_d   = do_issue;
    assign iss_err_d = do_issue && ((issue_a == '0) || (issue_a >= p_q));

`ifdef INV_CHECK_EN
    logic                chk_v_q, chk_err_q;
    logic [IP_WIDTH-1:0] chk_a_q, chk_inv_q;
    logic [2*IP_WIDTH-1:0] chk_prod, chk_mod;
    logic                chk_fail;

    assign chk_prod = {{IP_WIDTH{1'b0}}, chk_a_q} * {{IP_WIDTH{1'b0}}, chk_inv_q};
    assign chk_mod  = (p_q == '0) ? '0 : chk_prod % {{IP_WIDTH{1'b0}}, p_q};
    assign chk_fail = chk_err_q || (chk_mod != {{(2*IP_WIDTH-1){1'b0}}, 1'b1});

    assign out_valid_d = chk_v_q;
    assign out_err_d   = chk_v_q && chk_fail;
    assign out_data_d  = (chk_v_q && !chk_fail) ? chk_inv_q : '0;
    assign pipe_empty  = !iss_v_q && !chk_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_v_q   <= 1'b0;
            chk_err_q <= 1'b0;
            chk_a_q   <= '0;
            chk_inv_q <= '0;
        end else begin
            chk_v_q   <= iss_v_q;
            chk_err_q <= iss_err_q;
            chk_a_q   <= ip_in_1_q;
            chk_inv_q <= ip_out_inv;
        end
    end
`else
    assign out_valid_d = iss_v_q;
    assign out_err_d   = iss_v_q && iss_err_q;
    assign out_data_d  = (iss_v_q && !iss_err_q) ? ip_out_inv : '0;
    assign pipe_empty  = !iss_v_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            ip_in_1_q   <= '0;
            ip_in_2_q   <= '0;
            iss_v_q     <= 1'b0;
            iss_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            ip_in_1_q   <= ip_in_1_d;
            ip_in_2_q   <= ip_in_2_d;
            iss_v_q     <= iss_v_d;
            iss_err_q   <= iss_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    // NOTE: the operand buffer is storage only; it is never read before being written, so it has no reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[count_q[AW-1:0]] <= in_data;
    end

    assign ip_in_1   = ip_in_1_q;
    assign ip_in_2   = ip_in_2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// Self-checking bench for inv_seq_ctrl: models the inversion IP and predicts the result stream from packet rules.
module tb_inv_seq_ctrl;

    localparam int W  = 5;
    localparam int ML = 8;
`ifdef INV_CHECK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] ip_in_1, ip_in_2, ip_out_inv;
    logic         out_valid, out_err, busy;
    logic [W-1:0] out_data;
    bit           stub_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int           cyc;
        logic         err;
        logic [W-1:0] data;
    } exp_t;

    exp_t     expq[$];
    logic [W:0] obs[$];
    int       ops[16];

    inv_seq_ctrl #(.IP_WIDTH(W), .MAX_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .ip_in_1(ip_in_1), .ip_in_2(ip_in_2), .ip_out_inv(ip_out_inv),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modinv(input int a, input int p);
        for (int x = 1; x < p; x++) if ((a * x) % p == 1) return x;
        return 0;
    endfunction

    // Invalid operands get a nonzero junk answer so a missing error path shows up.
    function automatic int ip_model(input int a, input int p);
        if (a != 0 && a < p) return modinv(a, p);
        return (a ^ p) | 1;
    endfunction

    always_comb ip_out_inv = stub_en ? W'(1) : W'(ip_model(int'(ip_in_1), int'(ip_in_2)));

    function automatic logic [W:0] expect_beat(input int a, input int p);
        int v;
        bit bad;
        v   = stub_en ? 1 : ip_model(a, p);
        bad = (a == 0) || (a >= p);
`ifdef INV_CHECK_EN
        if (!bad && ((a * v) % p) != 1) bad = 1'b1;
`endif
        return bad ? {1'b1, W'(0)} : {1'b0, W'(v)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the scheduled expected stream.
    always @(negedge clk) begin
        if (rst_n) begin
            logic         ev;
            logic         ee;
            logic [W-1:0] ed;
            ev = 1'b0; ee = 1'b0; ed = '0;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                ev = 1'b1; ee = expq[0].err; ed = expq[0].data;
                void'(expq.pop_front());
            end
            check("stream", {25'd0, out_valid, out_err, out_data}, {25'd0, ev, ee, ed});
            if (out_valid) obs.push_back({out_err, out_data});
        end
    end

    task automatic send(input int p, input int n, input bit pulse);
        int c;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(p);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_data = W'(ops[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        c = cyc;
        for (int i = 0; i < n && i < ML; i++) begin
            exp_t e;
            e.cyc = c + LAT + i;
            {e.err, e.data} = expect_beat(ops[i], p);
            expq.push_back(e);
        end
        if (pulse) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int primes[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
        int p, n;

        #12;
        check("reset_out", {16'd0, busy, out_valid, out_err, out_data, ip_in_1, ip_in_2}, 32'd0);
        check("model_inv_3_7", modinv(3, 7), 5);
        check("model_inv_2_31", modinv(2, 31), 16);
        check("model_inv_6_7", modinv(6, 7), 6);
        check("model_inv_2_5", modinv(2, 5), 3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        obs.delete();
        ops[0] = 3; ops[1] = 2; ops[2] = 6;
        send(7, 3, 1'b0);
        wait_idle();
        check("p7_count", obs.size(), 3);
        check("p7_b0", {26'd0, obs[0]}, {26'd0, 1'b0, 5'd5});
        check("p7_b1", {26'd0, obs[1]}, {26'd0, 1'b0, 5'd4});
        check("p7_b2", {26'd0, obs[2]}, {26'd0, 1'b0, 5'd6});

        obs.delete();
        ops[0] = 2;
        send(31, 1, 1'b0);
        wait_idle();
        check("p31_count", obs.size(), 1);
        check("p31_b0", {26'd0, obs[0]}, {26'd0, 1'b0, 5'd16});

        obs.delete();
        ops[0] = 0; ops[1] = 13; ops[2] = 20; ops[3] = 1;
        send(13, 4, 1'b0);
        wait_idle();
        check("p13_count", obs.size(), 4);
        check("p13_b0", {26'd0, obs[0]}, {26'd0, 1'b1, 5'd0});
        check("p13_b1", {26'd0, obs[1]}, {26'd0, 1'b1, 5'd0});
        check("p13_b2", {26'd0, obs[2]}, {26'd0, 1'b1, 5'd0});
        check("p13_b3", {26'd0, obs[3]}, {26'd0, 1'b0, 5'd1});

        obs.delete();
        for (int i = 0; i < 10; i++) ops[i] = i + 1;
        send(11, 10, 1'b0);
        wait_idle();
        check("overflow_count", obs.size(), 8);

        obs.delete();
        send(7, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("prime_only_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("prime_only_count", obs.size(), 0);

        obs.delete();
        ops[0] = 3; ops[1] = 5; ops[2] = 7; ops[3] = 9;
        send(17, 4, 1'b1);
        wait_idle();
        check("pulse_count", obs.size(), 4);

        ops[0] = 3; ops[1] = 2; ops[2] = 6;
        send(7, 3, 1'b0);
        repeat (LAT + 1) @(posedge clk);
        #1;
        check("rst_2nd_beat_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {16'd0, busy, out_valid, out_err, out_data, ip_in_1, ip_in_2}, 32'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        obs.delete();
        ops[0] = 2;
        send(5, 1, 1'b0);
        wait_idle();
        check("after_rst_count", obs.size(), 1);
        check("after_rst_b0", {26'd0, obs[0]}, {26'd0, 1'b0, 5'd3});

`ifdef INV_CHECK_EN
        obs.delete();
        stub_en = 1'b1;
        ops[0] = 3;
        send(7, 1, 1'b0);
        wait_idle();
        stub_en = 1'b0;
        check("stub_count", obs.size(), 1);
        check("stub_b0", {26'd0, obs[0]}, {26'd0, 1'b1, 5'd0});
`endif

        for (int t = 0; t < 25; t++) begin
            p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : primes[$urandom_range(0, 10)];
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++)
                ops[i] = ($urandom_range(0, 3) == 0 || p < 2) ? int'($urandom_range(0, 31))
                                                               : int'($urandom_range(1, p - 1));
            send(p, n, (n >= 2) && ($urandom_range(0, 1) == 1));
            wait_idle();
        end
        check("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
